// File: rtl/if_fetch_pkg.sv
// Shared types, constants and helpers for the instruction-fetch controller.
package if_fetch_pkg;

  // Exception codes returned alongside each fetch response.
  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_ADDR    = 2'd1,
    EXC_BUS     = 2'd2,
    EXC_TIMEOUT = 2'd3
  } exc_code_e;

  // Controller states; a cache request is outstanding in both non-idle states.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CACHE_WAIT = 2'd1,
    ST_DRAIN      = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_UNCACHE_BASE = 32'hBFC0_0000;
  localparam logic [31:0] DEF_TEXT_LIMIT   = 32'h7FFF_FFFF;
  localparam logic [31:0] DEF_MEM_LIMIT    = 32'hFFFF_FFFF;

  // True when pc lies in [base, base + 4*depth - 1]. Evaluated in 64 bits so
  // a window ending at the top of the address space cannot wrap.
  function automatic logic uncache_hit(input logic [63:0] pc,
                                       input logic [63:0] base,
                                       input int unsigned depth);
    logic [63:0] last;
    last = base + (64'(depth) << 2) - 64'd1;
    return (pc >= base) && (pc <= last);
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side and cache-side handshake signals of the fetch controller.
// The controller uses the slave view; the pipeline/cache side uses master.
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INS_W  = 32
) ();

  // Pipeline fetch request and response
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              um;
  logic              erl;
  logic              flush;
  logic              fetch_ready;
  logic              ins_valid;
  logic [INS_W-1:0]  ins;
  logic [1:0]        exc_code;

  // L1 I-cache request/ack
  logic              cache_req;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_ack;
  logic [INS_W-1:0]  cache_data;
  logic              cache_err;

  modport slave (
    input  fetch_valid, fetch_pc, um, erl, flush,
    input  cache_ack, cache_data, cache_err,
    output fetch_ready, ins_valid, ins, exc_code,
    output cache_req, cache_addr
  );

  modport master (
    output fetch_valid, fetch_pc, um, erl, flush,
    output cache_ack, cache_data, cache_err,
    input  fetch_ready, ins_valid, ins, exc_code,
    input  cache_req, cache_addr
  );

endinterface

// File: rtl/if_uncache_buf.sv
// Instruction buffer backing the uncached window: one write port, one
// registered read port. A read and write to the same index in the same cycle
// returns the previous contents. Contents are intentionally not reset.
module if_uncache_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int          INS_W = 32,
  localparam int         IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [INS_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [INS_W-1:0] rdata_o
);

  logic [INS_W-1:0] mem_q [DEPTH];
  logic [INS_W-1:0] rdata_q;

  // Write and registered read share one process so a collision reads old data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: validates fetch PCs, serves the uncached
// window from a local buffer, forwards the rest to the L1 I-cache and returns
// exactly one registered response per accepted fetch.
module if_fetch_ctrl
  import if_fetch_pkg::*;
#(
  parameter int                 ADDR_W       = 32,
  parameter int                 INS_W        = 32,
  parameter int unsigned        UBUF_DEPTH   = 16,
  parameter logic [ADDR_W-1:0]  UNCACHE_BASE = DEF_UNCACHE_BASE,
  parameter logic [ADDR_W-1:0]  TEXT_LIMIT   = DEF_TEXT_LIMIT,
  parameter logic [ADDR_W-1:0]  MEM_LIMIT    = DEF_MEM_LIMIT,
  parameter int                 TIMEOUT      = 255,
  localparam int                IDX_W        = $clog2(UBUF_DEPTH),
  localparam int                CNT_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  if_fetch_ctrl_if.slave    bus,
  input  logic              ubuf_we_i,
  input  logic [IDX_W-1:0]  ubuf_waddr_i,
  input  logic [INS_W-1:0]  ubuf_wdata_i
);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_ubuf_q,  rsp_ubuf_d;
  exc_code_e         rsp_exc_q,   rsp_exc_d;
  logic [INS_W-1:0]  rsp_ins_q,   rsp_ins_d;

  logic              fetch_ready;
  logic              cache_req;
  logic              accept;
  logic              uc_hit;
  logic              addr_err;
  logic              expire;
  logic              ubuf_re;
  logic              go_cache;
  logic [IDX_W-1:0]  ubuf_raddr;
  logic [INS_W-1:0]  ubuf_rdata;

  // A flush blocks acceptance even while the controller is idle.
  assign accept   = bus.fetch_valid && (state_q == ST_IDLE) && !bus.flush;
  assign uc_hit   = uncache_hit(64'(bus.fetch_pc), 64'(UNCACHE_BASE), UBUF_DEPTH);
  assign ubuf_re  = accept && !addr_err && uc_hit;
  assign go_cache = accept && !addr_err && !uc_hit;
  assign expire   = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign ubuf_raddr = IDX_W'((bus.fetch_pc - UNCACHE_BASE) >> 2);

  // Address legality checks, highest priority first.
  always_comb begin
    addr_err = 1'b0;
    if (bus.fetch_pc[1:0] != 2'b00) begin
      addr_err = 1'b1;
    end else if (bus.um && (bus.fetch_pc > TEXT_LIMIT)) begin
      addr_err = 1'b1;
    end else if (!bus.um && (bus.fetch_pc > MEM_LIMIT)) begin
      addr_err = 1'b1;
    end else if (!bus.um && bus.erl && !uc_hit) begin
      addr_err = 1'b1;
    end
  end

  if_uncache_buf #(
    .DEPTH (UBUF_DEPTH),
    .INS_W (INS_W)
  ) u_ubuf (
    .clk     (clk),
    .we_i    (ubuf_we_i),
    .waddr_i (ubuf_waddr_i),
    .wdata_i (ubuf_wdata_i),
    .re_i    (ubuf_re),
    .raddr_i (ubuf_raddr),
    .rdata_o (ubuf_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ack beats timeout, timeout beats flush; DRAIN ignores flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_cache) state_d = ST_CACHE_WAIT;
      end
      ST_CACHE_WAIT: begin
        if (bus.cache_ack || expire) state_d = ST_IDLE;
        else if (bus.flush)          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.cache_ack || expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and next response: the request stays up until ack or timeout.
  always_comb begin
    fetch_ready = (state_q == ST_IDLE);
    cache_req   = (state_q != ST_IDLE);
    rsp_valid_d = 1'b0;
    rsp_ubuf_d  = 1'b0;
    rsp_exc_d   = EXC_NONE;
    rsp_ins_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && addr_err) begin
          rsp_valid_d = 1'b1;
          rsp_exc_d   = EXC_ADDR;
        end else if (ubuf_re) begin
          rsp_valid_d = 1'b1;
          rsp_ubuf_d  = 1'b1;
        end
      end
      ST_CACHE_WAIT: begin
        if (bus.cache_ack) begin
          rsp_valid_d = 1'b1;
          rsp_exc_d   = bus.cache_err ? EXC_BUS : EXC_NONE;
          rsp_ins_d   = bus.cache_err ? '0 : bus.cache_data;
        end else if (expire) begin
          rsp_valid_d = 1'b1;
          rsp_exc_d   = EXC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Response, request address and timeout counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      rsp_ubuf_q  <= 1'b0;
      rsp_exc_q   <= EXC_NONE;
      rsp_ins_q   <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_ubuf_q  <= rsp_ubuf_d;
      rsp_exc_q   <= rsp_exc_d;
      rsp_ins_q   <= rsp_ins_d;
      if (go_cache) begin
        addr_q <= bus.fetch_pc;
        cnt_q  <= '0;
      end else if ((state_q != ST_IDLE) && !bus.cache_ack && !expire) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Response fields read as zero outside the valid pulse.
  assign bus.fetch_ready = fetch_ready;
  assign bus.cache_req   = cache_req;
  assign bus.cache_addr  = cache_req ? addr_q : '0;
  assign bus.ins_valid   = rsp_valid_q;
  assign bus.ins         = !rsp_valid_q ? '0 : (rsp_ubuf_q ? ubuf_rdata : rsp_ins_q);
  assign bus.exc_code    = rsp_valid_q ? rsp_exc_q : EXC_NONE;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a hand-driven cache responder.
module tb_if_fetch_ctrl;

  localparam logic [31:0] UB = 32'hBFC0_0000;

  logic        clk;
  logic        resetn;
  logic        ubuf_we;
  logic [3:0]  ubuf_waddr;
  logic [31:0] ubuf_wdata;
  int          n_checks;
  int          n_errors;

  if_fetch_ctrl_if #(.ADDR_W(32), .INS_W(32)) bus ();

  if_fetch_ctrl #(
    .ADDR_W(32), .INS_W(32), .UBUF_DEPTH(16),
    .UNCACHE_BASE(32'hBFC0_0000), .TEXT_LIMIT(32'h7FFF_FFFF),
    .MEM_LIMIT(32'hFFFF_FFFF), .TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .ubuf_we_i    (ubuf_we),
    .ubuf_waddr_i (ubuf_waddr),
    .ubuf_wdata_i (ubuf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ubuf_write(input logic [3:0] idx, input logic [31:0] data);
    ubuf_we = 1'b1; ubuf_waddr = idx; ubuf_wdata = data;
    @(posedge clk); #1;
    ubuf_we = 1'b0;
  endtask

  // One-cycle fetch (uncached or faulting): response expected right after the edge.
  task automatic fetch1(input string tag, input logic [31:0] pc, input logic u, input logic e,
                        input logic [1:0] xexc, input logic [31:0] xins);
    bus.fetch_valid = 1'b1; bus.fetch_pc = pc; bus.um = u; bus.erl = e;
    chk({tag, "_rdy"}, 64'(bus.fetch_ready), 64'd1);
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    $display("txn %s pc=%h um=%0b erl=%0b -> valid=%0b exc=%0d ins=%h",
             tag, pc, u, e, bus.ins_valid, bus.exc_code, bus.ins);
    chk({tag, "_valid"}, 64'(bus.ins_valid), 64'd1);
    chk({tag, "_exc"},   64'(bus.exc_code),  64'(xexc));
    chk({tag, "_ins"},   64'(bus.ins),       64'(xins));
    chk({tag, "_req"},   64'(bus.cache_req), 64'd0);
  endtask

  // Cached fetch; cycle c counts cycles with cache_req high (c=1 first).
  // ack_cyc / flush_cyc = 0 means never. x_resp = cycle of the response, 0 = none.
  task automatic cached_run(input string tag, input logic [31:0] pc, input logic u,
                            input int ack_cyc, input int flush_cyc, input logic err,
                            input logic [31:0] data, input int x_req, input int x_resp,
                            input logic [1:0] xexc, input logic [31:0] xins);
    int req_cyc, resp_at, n_resp;
    logic addr_bad, ready_bad;
    logic [1:0] rexc;
    logic [31:0] rins;
    req_cyc = 0; resp_at = 0; n_resp = 0; addr_bad = 1'b0; ready_bad = 1'b0;
    rexc = 2'd0; rins = 32'd0;
    bus.fetch_valid = 1'b1; bus.fetch_pc = pc; bus.um = u; bus.erl = 1'b0;
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (!bus.cache_req) break;
      req_cyc++;
      if (bus.cache_addr !== pc) addr_bad = 1'b1;
      if (bus.fetch_ready) ready_bad = 1'b1;
      bus.cache_ack  = (c == ack_cyc);
      bus.cache_err  = (c == ack_cyc) ? err : 1'b0;
      bus.cache_data = (c == ack_cyc) ? data : 32'd0;
      bus.flush      = (c == flush_cyc);
      @(posedge clk); #1;
      bus.cache_ack = 1'b0; bus.cache_err = 1'b0; bus.cache_data = 32'd0; bus.flush = 1'b0;
      if (bus.ins_valid) begin
        n_resp++; resp_at = c; rexc = bus.exc_code; rins = bus.ins;
      end
    end
    $display("txn %s pc=%h req_cycles=%0d resp_cycle=%0d exc=%0d ins=%h",
             tag, pc, req_cyc, resp_at, rexc, rins);
    chk({tag, "_reqcyc"},  64'(req_cyc),         64'(x_req));
    chk({tag, "_nresp"},   64'(n_resp),          64'((x_resp != 0) ? 1 : 0));
    chk({tag, "_respat"},  64'(resp_at),         64'(x_resp));
    chk({tag, "_exc"},     64'(rexc),            64'(xexc));
    chk({tag, "_ins"},     64'(rins),            64'(xins));
    chk({tag, "_addr"},    64'(addr_bad),        64'd0);
    chk({tag, "_busyrdy"}, 64'(ready_bad),       64'd0);
    chk({tag, "_rdy"},     64'(bus.fetch_ready), 64'd1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    resetn = 1'b0; ubuf_we = 1'b0; ubuf_waddr = 4'd0; ubuf_wdata = 32'd0;
    bus.fetch_valid = 1'b0; bus.fetch_pc = 32'd0; bus.um = 1'b0; bus.erl = 1'b0;
    bus.flush = 1'b0; bus.cache_ack = 1'b0; bus.cache_data = 32'd0; bus.cache_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.fetch_ready), 64'd1);
    chk("rst_valid", 64'(bus.ins_valid),   64'd0);
    chk("rst_req",   64'(bus.cache_req),   64'd0);
    chk("rst_addr",  64'(bus.cache_addr),  64'd0);
    chk("rst_exc",   64'(bus.exc_code),    64'd0);
    chk("rst_ins",   64'(bus.ins),         64'd0);
    resetn = 1'b1;

    // Uncached window reads, including the last entry
    ubuf_write(4'd2,  32'h2400_0001);
    ubuf_write(4'd15, 32'hAAAA_0015);
    fetch1("uc_idx2",  UB + 32'h8,  1'b0, 1'b1, 2'd0, 32'h2400_0001);
    fetch1("uc_idx15", UB + 32'h3C, 1'b0, 1'b1, 2'd0, 32'hAAAA_0015);

    // Back-to-back address errors, one per cycle
    fetch1("ae_align", 32'h0040_0002, 1'b0, 1'b0, 2'd1, 32'd0);
    fetch1("ae_user",  32'h8000_0000, 1'b1, 1'b0, 2'd1, 32'd0);
    fetch1("ae_erl",   32'h0040_0000, 1'b0, 1'b1, 2'd1, 32'd0);
    fetch1("ae_winend", UB + 32'h40, 1'b0, 1'b1, 2'd1, 32'd0);
    @(posedge clk); #1;
    chk("pulse_end", 64'(bus.ins_valid), 64'd0);

    // Same-cycle write to the read index returns old data, then new data
    ubuf_write(4'd5, 32'h1111_1111);
    ubuf_we = 1'b1; ubuf_waddr = 4'd5; ubuf_wdata = 32'h2222_2222;
    fetch1("uc_coll_old", UB + 32'h14, 1'b0, 1'b1, 2'd0, 32'h1111_1111);
    ubuf_we = 1'b0;
    fetch1("uc_coll_new", UB + 32'h14, 1'b0, 1'b1, 2'd0, 32'h2222_2222);

    // Flush blocks acceptance
    bus.fetch_valid = 1'b1; bus.flush = 1'b1; bus.fetch_pc = UB + 32'h8; bus.erl = 1'b1;
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_noacc_valid", 64'(bus.ins_valid), 64'd0);
    chk("flush_noacc_req",   64'(bus.cache_req), 64'd0);

    // Cached fetches
    cached_run("c_ok",      32'h0040_0000, 1'b1, 3, 0, 1'b0, 32'h8C21_0004, 3, 3, 2'd0, 32'h8C21_0004);
    cached_run("c_err",     32'h0040_0000, 1'b1, 3, 0, 1'b1, 32'h8C21_0004, 3, 3, 2'd2, 32'd0);
    cached_run("c_tmo",     32'h0040_0004, 1'b1, 0, 0, 1'b0, 32'd0,         8, 8, 2'd3, 32'd0);
    cached_run("c_ackwins", 32'h0040_0008, 1'b0, 8, 0, 1'b0, 32'h1234_5678, 8, 8, 2'd0, 32'h1234_5678);
    cached_run("c_ulimit",  32'h7FFF_FFFC, 1'b1, 1, 0, 1'b0, 32'hCAFE_0001, 1, 1, 2'd0, 32'hCAFE_0001);
    cached_run("c_drain",   32'h0040_0010, 1'b0, 4, 1, 1'b0, 32'hDEAD_BEEF, 4, 0, 2'd0, 32'd0);
    cached_run("c_drntmo",  32'h0040_0014, 1'b0, 0, 1, 1'b0, 32'd0,         8, 0, 2'd0, 32'd0);

    // Reset during CACHE_WAIT
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0040_0020; bus.um = 1'b0; bus.erl = 1'b0;
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    chk("mr_req_up", 64'(bus.cache_req), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    $display("txn midreset req=%0b valid=%0b ready=%0b", bus.cache_req, bus.ins_valid, bus.fetch_ready);
    chk("mr_req",   64'(bus.cache_req),   64'd0);
    chk("mr_valid", 64'(bus.ins_valid),   64'd0);
    chk("mr_ready", 64'(bus.fetch_ready), 64'd1);
    fetch1("mr_uc", UB + 32'h8, 1'b0, 1'b1, 2'd0, 32'h2400_0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
